// File: rtl/video_timing_pkg.sv
// Shared constants for the video timing generator.
// Holds the default 720p60 raster timing, counter width, pattern select codes
// and the colour-bar palette used by the bars pattern.
package video_timing_pkg;

  // Counter width; wide enough for the largest default total (1650 clocks per line).
  localparam int unsigned CNT_W = 12;

  // Default 720p60 timing.
  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_V_ACTIVE = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;

  // Pattern select codes; any other code shows black.
  localparam logic [7:0] PAT_BARS  = 8'd0;
  localparam logic [7:0] PAT_RAMP  = 8'd1;
  localparam logic [7:0] PAT_CHECK = 8'd2;

  // Colours packed as {R, G, B}.
  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  // Colour of bar idx, left to right.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with sync and active-region decode.
// Ports:
//   clock, reset_n       pixel clock, async active-low reset
//   h_cnt, v_cnt         current raster position
//   h_last               h_cnt is at the last clock of the line
//   frame_last           last clock of the last line of the frame
//   active               position is inside the active picture
//   hs_act, vs_act       position is inside the horizontal / vertical sync pulse
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             h_last,
  output logic             frame_last,
  output logic             active,
  output logic             hs_act,
  output logic             vs_act
);

  localparam logic [CNT_W-1:0] HLast   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] HAct    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncS  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncE  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VLast   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] VAct    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VSyncS  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncE  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             v_last;

  assign h_last     = (h_cnt_q == HLast);
  assign v_last     = (v_cnt_q == VLast);
  assign frame_last = h_last && v_last;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt  = h_cnt_q;
  assign v_cnt  = v_cnt_q;
  assign active = (h_cnt_q < HAct) && (v_cnt_q < VAct);
  // vs decodes on v_cnt only, so its edges land on h_cnt = 0.
  assign hs_act = (h_cnt_q >= HSyncS) && (h_cnt_q < HSyncE);
  assign vs_act = (v_cnt_q >= VSyncS) && (v_cnt_q < VSyncE);

endmodule

// File: rtl/video_timing_gen.sv
// Test-pattern video source: raster timing plus bars / ramp / checkerboard fill.
// Ports:
//   clock, reset_n        pixel clock, async active-low reset
//   pattern_mode_i        pattern select, taken once per frame on the last clock
//   vs_o, hs_o, de_o      sync and data enable, polarity set by VS_POL / HS_POL
//   rgb_r_o/g_o/b_o       pixel colour, 0 outside the active region
//   sof_o                 one-clock pulse with pixel (0,0)
// All outputs are registered and show position (h,v) one clock after the counters hold it.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] pattern_mode_i,
  output logic       vs_o,
  output logic       hs_o,
  output logic       de_o,
  output logic [7:0] rgb_r_o,
  output logic [7:0] rgb_g_o,
  output logic [7:0] rgb_b_o,
  output logic       sof_o
);

  localparam logic [CNT_W-1:0] BarLast = CNT_W'(H_ACTIVE / 8 - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, frame_last, active, hs_act, vs_act;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .h_last     (h_last),
    .frame_last (frame_last),
    .active     (active),
    .hs_act     (hs_act),
    .vs_act     (vs_act)
  );

  logic [7:0]       mode_q, mode_d;
  logic [2:0]       bar_q, bar_d;
  logic [CNT_W-1:0] bar_px_q, bar_px_d;
  logic [23:0]      pix_rgb;
  logic [23:0]      rgb_q, rgb_d;
  logic             vs_q, vs_d, hs_q, hs_d, de_q, de_d, sof_q, sof_d;

  // Mode changes only between frames so a picture is never mixed.
  assign mode_d = frame_last ? pattern_mode_i : mode_q;

  // bar_q is the bar index of the current h_cnt; it saturates at 7 so the
  // last bar absorbs any remainder of H_ACTIVE / 8.
  always_comb begin
    bar_d    = bar_q;
    bar_px_d = bar_px_q + 1'b1;
    if (h_last) begin
      bar_d    = '0;
      bar_px_d = '0;
    end else if (bar_px_q == BarLast) begin
      bar_px_d = '0;
      bar_d    = (bar_q == 3'd7) ? bar_q : bar_q + 1'b1;
    end
  end

  always_comb begin
    pix_rgb = COL_BLACK;
    case (mode_q)
      PAT_BARS:  pix_rgb = bar_color(bar_q);
      PAT_RAMP:  pix_rgb = {3{h_cnt[7:0]}};
      PAT_CHECK: pix_rgb = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? COL_BLACK : COL_WHITE;
      default:   pix_rgb = COL_BLACK;
    endcase
  end

  always_comb begin
    rgb_d = active ? pix_rgb : '0;
    de_d  = active;
    hs_d  = hs_act ? HS_POL : ~HS_POL;
    vs_d  = vs_act ? VS_POL : ~VS_POL;
    sof_d = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= PAT_BARS;
      bar_q    <= '0;
      bar_px_q <= '0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      sof_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      bar_q    <= bar_d;
      bar_px_q <= bar_px_d;
      rgb_q    <= rgb_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      sof_q    <= sof_d;
    end
  end

  assign vs_o    = vs_q;
  assign hs_o    = hs_q;
  assign de_o    = de_q;
  assign sof_o   = sof_q;
  assign rgb_r_o = rgb_q[23:16];
  assign rgb_g_o = rgb_q[15:8];
  assign rgb_b_o = rgb_q[7:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 24x8 raster (16x4 active).
module tb_video_timing_gen;

  localparam int HTot = 24;
  localparam int VTot = 8;
  localparam int FTot = HTot * VTot;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pattern_mode_i = 8'd0;
  logic       vs_o, hs_o, de_o, sof_o;
  logic [7:0] rgb_r_o, rgb_g_o, rgb_b_o;

  video_timing_gen #(
    .H_ACTIVE   (16),
    .H_FP       (2),
    .H_SYNC     (3),
    .H_BP       (3),
    .V_ACTIVE   (4),
    .V_FP       (1),
    .V_SYNC     (2),
    .V_BP       (1),
    .HS_POL     (1'b1),
    .VS_POL     (1'b1),
    .CHECK_LOG2 (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pattern_mode_i (pattern_mode_i),
    .vs_o           (vs_o),
    .hs_o           (hs_o),
    .de_o           (de_o),
    .rgb_r_o        (rgb_r_o),
    .rgb_g_o        (rgb_g_o),
    .rgb_b_o        (rgb_b_o),
    .sof_o          (sof_o)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-chosen pattern per frame: bars, ramp, checker, 7 (black), then bars
  // after the mid-frame reset, then ramp.
  int exp_mode [6] = '{0, 1, 2, 7, 0, 1};
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int pix = 0;
  int frame = 0;
  int de_cnt = 0, vs_cnt = 0, sof_cnt = 0, hs_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s frame=%0d pix=%0d got=%0h exp=%0h", tag, frame, pix, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int mode, input int h, input int v);
    logic [7:0] hb;
    hb = 8'(h);
    if (!(h < 16 && v < 4)) return 24'h0;
    case (mode)
      0:       return bars[h / 2];
      1:       return {hb, hb, hb};
      2:       return (hb[2] ^ v[2]) ? 24'h000000 : 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_de"}, de_o, 0);
    check({tag, "_sof"}, sof_o, 0);
    check({tag, "_hs"}, hs_o, 0);
    check({tag, "_vs"}, vs_o, 0);
    check({tag, "_rgb"}, {rgb_r_o, rgb_g_o, rgb_b_o}, 0);
  endtask

  // One clock edge; checks the pixel at position pix of the current frame.
  task automatic step();
    int h, v;
    @(posedge clock);
    #1;
    h = pix % HTot;
    v = pix / HTot;
    check("de", de_o, (h < 16 && v < 4) ? 1 : 0);
    check("hs", hs_o, (h >= 18 && h < 21) ? 1 : 0);
    check("vs", vs_o, (v >= 5 && v < 7) ? 1 : 0);
    check("sof", sof_o, (pix == 0) ? 1 : 0);
    check("rgb", {rgb_r_o, rgb_g_o, rgb_b_o}, exp_rgb(exp_mode[frame], h, v));
    de_cnt += de_o;
    vs_cnt += vs_o;
    hs_cnt += hs_o;
    sof_cnt += sof_o;
    if (pix == FTot - 1) begin
      check("frame_de_count", de_cnt, 64);
      check("frame_vs_count", vs_cnt, 48);
      check("frame_hs_count", hs_cnt, 24);
      check("frame_sof_count", sof_cnt, 1);
      de_cnt = 0; vs_cnt = 0; hs_cnt = 0; sof_cnt = 0;
      pix = 0;
      frame++;
    end else begin
      pix++;
    end
  endtask

  initial begin
    #12;
    check_reset_vals("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Frame 0 bars; mode 1 requested mid-frame must wait for frame 1.
    repeat (100) step();
    pattern_mode_i = 8'd1;
    repeat (FTot - 100) step();

    // Frame 1 ramp; request checkerboard mid-frame.
    repeat (50) step();
    pattern_mode_i = 8'd2;
    repeat (FTot - 50) step();

    // Frame 2 checker; code 7 present only on the load cycle must be taken.
    repeat (FTot - 1) step();
    pattern_mode_i = 8'd7;
    step();
    pattern_mode_i = 8'd1;

    // Frame 3 black; reset mid-line 1 while a ramp is requested.
    repeat (37) step();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("held_reset");
    @(negedge clock);
    reset_n = 1'b1;
    pix = 0; frame = 4;
    de_cnt = 0; vs_cnt = 0; hs_cnt = 0; sof_cnt = 0;

    // Frame 4 reverts to bars; frame 5 picks up the ramp request.
    repeat (FTot) step();
    repeat (HTot) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Source end of the pipeline's parallel video interface (vs/hs/de plus 8-bit R/G/B). Generates raster timing from programmable counters and fills the active region with a selectable test pattern, so processing blocks such as the negative/filter stages can run and be checked without an HDMI receiver. Sits at the head of the processing chain in place of the receiver output. The pattern select is sampled once per frame, so the picture never changes mid-frame.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal front porch / sync / back porch in clocks
- V_ACTIVE, 720, active lines per frame
- V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical front porch / sync / back porch in lines
- HS_POL / VS_POL, 1 / 1, sync active level (1 = active high)
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels
- clock  input  1  pixel clock; single clock domain
- reset_n  input  1  asynchronous, active-low reset
- pattern_mode_i  input  8  pattern select, sampled at frame boundary
- vs_o  output  1  vertical sync
- hs_o  output  1  horizontal sync
- de_o  output  1  data enable, high on active pixels
- rgb_r_o / rgb_g_o / rgb_b_o  output  8 each  pixel colour
- sof_o  output  1  one-cycle pulse coincident with pixel (0,0) of each frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments on h_cnt wrap and counts 0..V_TOTAL-1, then wraps.
- Line/frame order: active, front porch, sync, back porch. Active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hs active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vs active for whole lines V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, so vs edges coincide with h_cnt=0.
- Mode register loaded from pattern_mode_i when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. Reset value 0.
- Modes: 0 = eight vertical colour bars, BAR_W=H_ACTIVE/8 (integer), order white, yellow, cyan, green, magenta, red, blue, black at 00/FF levels. Bar index is a 3-bit counter that clears at h_cnt=0, advances every BAR_W pixels and saturates at 7, so the last bar absorbs the remainder. 1 = horizontal grey ramp, R=G=B=h_cnt[7:0]. 2 = checkerboard, white when h_cnt[CHECK_LOG2]^v_cnt[CHECK_LOG2]=0, else black. All other codes = black.
- Outside the active region RGB outputs are 0.

## Timing
- All outputs registered. Outputs for counter position (h,v) appear one clock after the counters hold (h,v). vs/hs/de/RGB/sof are mutually aligned.
- Reset: h_cnt=v_cnt=0, mode=0, de_o=0, sof_o=0, RGB=0, hs_o=~HS_POL, vs_o=~VS_POL.
- First clock edge after reset release presents pixel (0,0) with de_o=1 and sof_o=1.
- Reset asserted mid-frame returns outputs to reset values immediately (async). The raster restarts at (0,0); no partial-line recovery.
- A pattern_mode_i change takes effect from the first pixel of the next frame. A change on the exact load cycle is taken.

## Structure
- Package video_timing_pkg: default 720p60 timing constants, pattern codes (PAT_BARS=0, PAT_RAMP=1, PAT_CHECK=2), bar colour constants.
- Sub-module video_timing_counter: h/v counters plus sync/active decode. The top level adds the mode register, pattern logic and output registers.

## Test plan
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); CHECK_LOG2=2.
- Reset release -> next edge de_o=1 and sof_o=1, RGB=FF/FF/FF; de_o high 16 clocks then low 8 clocks; frame period 192 clocks; sof_o every 192 clocks.
- Sync placement -> hs_o high for h_cnt 18..20 each line; vs_o high for lines 5..6 (48 clocks), rising aligned with h_cnt=0.
- Mode 0 -> per line, pixel pairs give FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Mode 1 written mid-frame -> current frame stays bars; next frame line 0 RGB ramps 00..0F equal on all channels.
- Mode 2 -> line 0 pixels 0-3 white, 4-7 black, alternating; line 0 and line 3 identical within the 4 active lines; mode 7 -> all active pixels 000000.
- Reset pulse mid-line -> outputs at reset values during reset; raster restarts with sof_o one edge after release; mode reverts to bars.
